// File: rtl/fpmul_req_pkg.sv
// Shared types and constants for the FPMUL Start/Done requester.
// Flag vectors are ordered {OF,UF,NaNF,InfF,DNF,ZF}.
package fpmul_req_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    localparam int FLG_OF  = 5;
    localparam int FLG_UF  = 4;
    localparam int FLG_NAN = 3;
    localparam int FLG_INF = 2;
    localparam int FLG_DN  = 1;
    localparam int FLG_Z   = 0;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [5:0] flag_bit(input int idx);
        logic [5:0] mask;
        mask = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

    localparam logic [5:0] TIMEOUT_FLAGS = flag_bit(FLG_NAN);

endpackage

// File: rtl/fpmul_req_wdog.sv
// Watchdog counter for the requester: counts enabled cycles after a clear
// and raises expire once TIMEOUT_CYCLES-1 cycles have elapsed.
module fpmul_req_wdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the expiry value so a late enable cannot wrap the count.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fpmul_requester.sv
// Initiator for the FPMUL Start/Done interface: issues one operand pair at a
// time, waits for a Done rising edge (or watchdog timeout) and holds the result.
module fpmul_requester
    import fpmul_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] In_A,
    input  logic [31:0] In_B,
    output logic [31:0] Mul_A,
    output logic [31:0] Mul_B,
    output logic        Mul_Start,
    output logic        Mul_Rst,
    input  logic        Mul_Done,
    input  logic [31:0] Mul_P,
    input  logic [5:0]  Mul_Flags,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_P,
    output logic [5:0]  Out_Flags,
    output logic        Out_TO,
    output logic        Busy
);

    state_t state;
    logic   done_q;
    logic   done_edge;
    logic   wd_expire;

    assign In_Ready  = (state == IDLE) && Rst_n;
    assign Busy      = (state != IDLE);
    // A Done already high when Start is issued never produces an edge here.
    assign done_edge = Mul_Done && !done_q;

    fpmul_req_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wdog (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clear (state == ISSUE),
        .enable((state == WAIT) && !done_edge),
        .expire(wd_expire)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= IDLE;
            Mul_A     <= '0;
            Mul_B     <= '0;
            Mul_Start <= 1'b0;
            Mul_Rst   <= 1'b1;
            Out_Valid <= 1'b0;
            Out_P     <= '0;
            Out_Flags <= '0;
            Out_TO    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= Mul_Done;
            Mul_Start <= 1'b0;
            Mul_Rst   <= 1'b0;
            case (state)
                IDLE: begin
                    if (In_Valid && In_Ready) begin
                        Mul_A     <= In_A;
                        Mul_B     <= In_B;
                        Mul_Start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // The Done edge takes priority over a same-cycle expiry.
                    if (done_edge) begin
                        Out_P     <= Mul_P;
                        Out_Flags <= Mul_Flags;
                        Out_TO    <= 1'b0;
                        Out_Valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wd_expire) begin
                        Out_P     <= QNAN;
                        Out_Flags <= TIMEOUT_FLAGS;
                        Out_TO    <= 1'b1;
                        Out_Valid <= 1'b1;
                        Mul_Rst   <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (Out_Valid && Out_Ready) begin
                        Out_Valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_requester.sv
// Self-checking bench for fpmul_requester: a behavioural multiplier model plus
// directed and randomized operations checked against spec-level expectations.
module tb_fpmul_requester;

    localparam int T = 8;
    localparam logic [1:0] M_NORMAL = 2'd0;
    localparam logic [1:0] M_NEVER  = 2'd1;
    localparam logic [1:0] M_STICKY = 2'd2;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_A;
    logic [31:0] In_B;
    logic [31:0] Mul_A;
    logic [31:0] Mul_B;
    logic        Mul_Start;
    logic        Mul_Rst;
    logic        Mul_Done = 1'b0;
    logic [31:0] Mul_P = 32'h0;
    logic [5:0]  Mul_Flags = 6'h0;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_P;
    logic [5:0]  Out_Flags;
    logic        Out_TO;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  mdl_mode  = M_NORMAL;
    int          mdl_delay = 4;
    logic [31:0] mdl_p     = 32'h0;
    logic [5:0]  mdl_flags = 6'h0;
    int          mdl_cnt   = 0;

    always #5 Clk = ~Clk;

    fpmul_requester #(.TIMEOUT_CYCLES(T)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_A     (In_A),
        .In_B     (In_B),
        .Mul_A    (Mul_A),
        .Mul_B    (Mul_B),
        .Mul_Start(Mul_Start),
        .Mul_Rst  (Mul_Rst),
        .Mul_Done (Mul_Done),
        .Mul_P    (Mul_P),
        .Mul_Flags(Mul_Flags),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Out_P    (Out_P),
        .Out_Flags(Out_Flags),
        .Out_TO   (Out_TO),
        .Busy     (Busy)
    );

    // Multiplier model: drops Done on Start and raises it mdl_delay edges later.
    always @(posedge Clk) begin
        if (mdl_mode == M_STICKY) begin
            Mul_Done <= 1'b1;
            mdl_cnt  <= 0;
        end else if (Mul_Rst) begin
            Mul_Done <= 1'b0;
            mdl_cnt  <= 0;
        end else if (Mul_Start) begin
            Mul_Done <= 1'b0;
            Mul_P    <= $urandom;
            mdl_cnt  <= (mdl_mode == M_NEVER) ? 0 : mdl_delay;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                Mul_Done  <= 1'b1;
                Mul_P     <= mdl_p;
                Mul_Flags <= mdl_flags;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One full operation. Done is visible in WAIT cycle d+1, so it completes
    // normally when d+1 <= T; otherwise the watchdog fires after T WAIT cycles.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] mode, input int d,
                                 input logic [31:0] rp, input logic [5:0] rf,
                                 input int bp);
        bit          timed_out;
        int          exp_lat;
        logic [31:0] exp_p;
        logic [5:0]  exp_f;
        int          lat;
        int          starts;
        int          rsts;
        timed_out = (mode != M_NORMAL) || (d + 1 > T);
        exp_lat   = timed_out ? T + 2 : d + 3;
        exp_p     = timed_out ? 32'h7FC00000 : rp;
        exp_f     = timed_out ? 6'b001000 : rf;
        mdl_mode  = mode;
        mdl_delay = d;
        mdl_p     = rp;
        mdl_flags = rf;
        if (mode == M_STICKY) tick();
        checkOutput("in_ready_idle", In_Ready, 1);
        In_Valid = 1'b1;
        In_A     = a;
        In_B     = b;
        tick();
        In_Valid = 1'b0;
        In_A     = $urandom;
        In_B     = $urandom;
        checkOutput("mul_a", Mul_A, a);
        checkOutput("mul_b", Mul_B, b);
        checkOutput("start_cycle1", Mul_Start, 1);
        lat    = 1;
        starts = 0;
        rsts   = 0;
        while (!Out_Valid && lat < 100) begin
            starts += int'(Mul_Start);
            rsts   += int'(Mul_Rst);
            checkOutput("in_ready_busy", In_Ready, 0);
            tick();
            lat++;
        end
        starts += int'(Mul_Start);
        rsts   += int'(Mul_Rst);
        checkOutput("out_valid", Out_Valid, 1);
        if (!Out_Valid) return;
        checkOutput("latency", lat, exp_lat);
        checkOutput("out_p", Out_P, exp_p);
        checkOutput("out_flags", {26'h0, Out_Flags}, {26'h0, exp_f});
        checkOutput("out_to", Out_TO, timed_out);
        checkOutput("busy_hold", Busy, 1);
        In_Valid = 1'b1;
        for (int i = 0; i < bp; i++) begin
            tick();
            starts += int'(Mul_Start);
            rsts   += int'(Mul_Rst);
            checkOutput("bp_valid", Out_Valid, 1);
            checkOutput("bp_p", Out_P, exp_p);
            checkOutput("bp_in_ready", In_Ready, 0);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        starts += int'(Mul_Start);
        rsts   += int'(Mul_Rst);
        checkOutput("drain_valid", Out_Valid, 0);
        checkOutput("drain_in_ready", In_Ready, 1);
        checkOutput("mul_a_stable", Mul_A, a);
        checkOutput("start_count", starts, 1);
        checkOutput("mul_rst_count", rsts, timed_out ? 1 : 0);
    endtask

    initial begin
        int seen_valid;
        Rst_n     = 1'b0;
        In_Valid  = 1'b0;
        In_A      = '0;
        In_B      = '0;
        Out_Ready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_mul_rst", Mul_Rst, 1);
        checkOutput("rst_in_ready", In_Ready, 0);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_out_valid", Out_Valid, 0);
        checkOutput("rst_out_p", Out_P, 0);
        checkOutput("rst_out_to", Out_TO, 0);
        checkOutput("rst_mul_a", Mul_A, 0);
        checkOutput("rst_start", Mul_Start, 0);
        Rst_n = 1'b1;
        tick();
        checkOutput("rel_mul_rst", Mul_Rst, 0);
        checkOutput("rel_in_ready", In_Ready, 1);

        $display("[TB] basic op");
        applyStimulus(32'h3F800000, 32'h40000000, M_NORMAL, 4, 32'h40000000, 6'h00, 0);
        $display("[TB] backpressure");
        applyStimulus(32'h40400000, 32'h40800000, M_NORMAL, 2, 32'h41400000, 6'b000001, 5);
        $display("[TB] timeout");
        applyStimulus(32'h12345678, 32'h9ABCDEF0, M_NEVER, 0, 32'h0, 6'h0, 1);
        $display("[TB] race on final wait cycle");
        applyStimulus(32'h3F000000, 32'h3F000000, M_NORMAL, T - 1, 32'h3E800000, 6'b100010, 0);
        $display("[TB] one cycle too late");
        applyStimulus(32'h11111111, 32'h22222222, M_NORMAL, T, 32'h33333333, 6'b010100, 0);
        $display("[TB] sticky done");
        applyStimulus(32'h7F800000, 32'h00000000, M_STICKY, 0, 32'h0, 6'h0, 2);
        mdl_mode = M_NORMAL;
        applyStimulus(32'h40A00000, 32'h40C00000, M_NORMAL, 1, 32'h41F00000, 6'h00, 0);

        $display("[TB] reset mid-wait");
        mdl_mode  = M_NORMAL;
        mdl_delay = 6;
        In_Valid  = 1'b1;
        In_A      = 32'hCAFEF00D;
        In_B      = 32'h0BADBEEF;
        tick();
        In_Valid = 1'b0;
        tick();
        tick();
        checkOutput("mid_busy", Busy, 1);
        Rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_valid", Out_Valid, 0);
        checkOutput("mid_rst_busy", Busy, 0);
        checkOutput("mid_rst_mul_rst", Mul_Rst, 1);
        checkOutput("mid_rst_in_ready", In_Ready, 0);
        checkOutput("mid_rst_mul_a", Mul_A, 0);
        Rst_n = 1'b1;
        tick();
        checkOutput("mid_rel_mul_rst", Mul_Rst, 0);
        checkOutput("mid_rel_in_ready", In_Ready, 1);
        seen_valid = 0;
        repeat (12) begin
            tick();
            seen_valid += int'(Out_Valid);
        end
        checkOutput("mid_no_result", seen_valid, 0);
        applyStimulus(32'h3FC00000, 32'h40000000, M_NORMAL, 3, 32'h40400000, 6'h00, 1);

        $display("[TB] randomized ops");
        for (int i = 0; i < 10; i++) begin
            logic [1:0] m;
            m = ($urandom_range(0, 4) == 0) ? M_NEVER : M_NORMAL;
            applyStimulus($urandom, $urandom, m, int'($urandom_range(1, T + 1)),
                          $urandom, 6'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
